// File: rtl/mult_seq_pkg.sv
// Shared definitions for the iterative multiply sequencer: ALU control codes and FSM states.
// The NEG_* states exist only when MULT_SIGNED_EN is defined.
package mult_seq_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    localparam int ITER_LAST = 31;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ITER       = 3'd1,
        S_DONE       = 3'd2
`ifdef MULT_SIGNED_EN
        ,
        S_NEG_A      = 3'd3,
        S_NEG_B      = 3'd4,
        S_NEG_LO     = 3'd5,
        S_NEG_HI_NOT = 3'd6,
        S_NEG_HI_INC = 3'd7
`endif
    } state_t;

endpackage

// File: rtl/mult_seq_carry.sv
// Carry-out of a 32-bit add reconstructed from the two operand MSBs and the sum MSB,
// so a sequencer can recover bit 32 from an ALU that only returns 32 bits.
module mult_carry (
    input  logic a_msb,
    input  logic b_msb,
    input  logic sum_msb,
    output logic carry
);

    assign carry = (a_msb & b_msb) | ((a_msb | b_msb) & ~sum_msb);

endmodule

// File: rtl/mult_seq.sv
// 32x32->64 shift-and-add multiplier that borrows the shared ALU one operation per cycle.
// Define MULT_SIGNED_EN to compile in signed MULT (operand/result negation via the ALU).
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z
);

    state_t           state_reg;
    logic [4:0]       cnt_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             carry;

`ifdef MULT_SIGNED_EN
    logic             signed_reg;
    logic             neg_reg;
    logic             lo_zero_reg;
`else
    logic             unused_inputs;
    assign unused_inputs = ^{sgn, alu_z};
`endif

    mult_carry u_carry (
        .a_msb   (alu_a[WIDTH-1]),
        .b_msb   (alu_b[WIDTH-1]),
        .sum_msb (alu_out[WIDTH-1]),
        .carry   (carry)
    );

    // ALU drive is a pure function of the current state so alu_out is usable in the same cycle.
    always_comb begin
        alu_ctl = ALU_ADD;
        alu_a   = '0;
        alu_b   = '0;
        case (state_reg)
            S_ITER: begin
                alu_a = hi_reg;
                alu_b = mcand_reg;
            end
`ifdef MULT_SIGNED_EN
            S_NEG_A: begin
                alu_ctl = ALU_SUB;
                alu_b   = mcand_reg;
            end
            S_NEG_B, S_NEG_LO: begin
                alu_ctl = ALU_SUB;
                alu_b   = lo_reg;
            end
            S_NEG_HI_NOT: begin
                alu_ctl = ALU_NOR;
                alu_a   = hi_reg;
                alu_b   = hi_reg;
            end
            S_NEG_HI_INC: begin
                alu_a   = hi_reg;
                alu_b   = {{(WIDTH-1){1'b0}}, 1'b1};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            mcand_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef MULT_SIGNED_EN
            signed_reg  <= 1'b0;
            neg_reg     <= 1'b0;
            lo_zero_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        mcand_reg <= a;
                        lo_reg    <= b;
                        hi_reg    <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
`ifdef MULT_SIGNED_EN
                        signed_reg <= sgn;
                        neg_reg    <= a[WIDTH-1] ^ b[WIDTH-1];
                        state_reg  <= sgn ? S_NEG_A : S_ITER;
`else
                        state_reg  <= S_ITER;
`endif
                    end
                end
                S_ITER: begin
                    if (lo_reg[0])
                        {hi_reg, lo_reg} <= {carry, alu_out, lo_reg[WIDTH-1:1]};
                    else
                        {hi_reg, lo_reg} <= {1'b0, hi_reg, lo_reg[WIDTH-1:1]};
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'(ITER_LAST)) begin
                        cnt_reg <= '0;
`ifdef MULT_SIGNED_EN
                        if (signed_reg) begin
                            state_reg <= S_NEG_LO;
                        end else begin
                            state_reg <= S_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
`else
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
`endif
                    end
                end
`ifdef MULT_SIGNED_EN
                // Operands become magnitudes; the sign is restored on the 64-bit result.
                S_NEG_A: begin
                    if (mcand_reg[WIDTH-1])
                        mcand_reg <= alu_out;
                    state_reg <= S_NEG_B;
                end
                S_NEG_B: begin
                    if (lo_reg[WIDTH-1])
                        lo_reg <= alu_out;
                    state_reg <= S_ITER;
                end
                S_NEG_LO: begin
                    if (neg_reg)
                        lo_reg <= alu_out;
                    lo_zero_reg <= alu_z;
                    state_reg   <= S_NEG_HI_NOT;
                end
                S_NEG_HI_NOT: begin
                    if (neg_reg)
                        hi_reg <= alu_out;
                    state_reg <= S_NEG_HI_INC;
                end
                S_NEG_HI_INC: begin
                    // The +1 ripples into hi only when the low word negated to zero.
                    if (neg_reg && lo_zero_reg)
                        hi_reg <= alu_out;
                    state_reg <= S_DONE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
`endif
                S_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed vector table, hand-written corner sequences and
// random operations compared against a 64-bit arithmetic reference; a behavioural ALU sits beside it.
module tb_mult_seq;

    logic        clk = 1'b0;
    logic        reset, start, sgn;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_z;

`ifdef MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    mult_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sgn     (sgn),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .alu_ctl (alu_ctl),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_out (alu_out),
        .alu_z   (alu_z)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_ctl)
            4'b0010: alu_out = alu_a + alu_b;
            4'b0110: alu_out = alu_a - alu_b;
            4'b1100: alu_out = ~(alu_a | alu_b);
            default: alu_out = 32'h0;
        endcase
        alu_z = (alu_out == 32'h0);
    end

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic        vs;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic signed [63:0] sx, sy;
        if (s && SIGNED_EN) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end
        return {32'h0, x} * {32'h0, y};
    endfunction

    // One complete operation: checks busy window, latency, result, and hold after done.
    task automatic run_check(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                             input logic ts, input int inject, input logic [63:0] exp);
        int c;
        int lat_exp;
        logic bad;
        lat_exp = (ts && SIGNED_EN) ? 38 : 33;
        @(negedge clk);
        a = ta; b = tb_v; sgn = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        bad = 1'b0;
        while (done !== 1'b1 && c < 60) begin
            if (c == inject) begin
                start = 1'b1;
                a = 32'd9;
            end else begin
                start = 1'b0;
            end
            if (busy !== 1'b1) bad = 1'b1;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        $display("op %s a=%h b=%h sgn=%0d hi=%h lo=%h lat=%0d", nm, ta, tb_v, ts, hi, lo, c);
        check({nm, "_latency"}, 64'(c), 64'(lat_exp));
        check({nm, "_busy_window"}, {63'h0, bad}, 64'h0);
        check({nm, "_busy_at_done"}, {63'h0, busy}, 64'h0);
        check({nm, "_product"}, {hi, lo}, exp);
        @(negedge clk);
        check({nm, "_done_pulse"}, {62'h0, done, busy}, 64'h0);
        check({nm, "_hold"}, {hi, lo}, exp);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          waitc;
        logic        seen_done;

        reset = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {30'h0, busy, done, hi}, 64'h0);
        check("reset_lo", {32'h0, lo}, 64'h0);
        check("idle_alu", {20'h0, alu_ctl, alu_a, alu_b}, {20'h0, 4'b0010, 64'h0});
        reset = 1'b0;

        vecs.push_back('{32'd3, 32'd5, 1'b0, 32'h0, 32'd15});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{32'h0, 32'h0, 1'b1, 32'h0, 32'h0});
`ifdef MULT_SIGNED_EN
        vecs.push_back('{32'hFFFFFFF9, 32'd6, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFD6});
        vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h1});
        vecs.push_back('{32'h00000004, 32'h80000000, 1'b1, 32'hFFFFFFFE, 32'h0});
`else
        vecs.push_back('{32'hFFFFFFFF, 32'd2, 1'b1, 32'h1, 32'hFFFFFFFE});
`endif
        for (int i = 0; i < vecs.size(); i++)
            run_check($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vs, -1,
                      {vecs[i].ehi, vecs[i].elo});

        // Start pulse while busy must be ignored.
        run_check("busy_start", 32'd3, 32'd5, 1'b0, 5, 64'd15);

        // Reset during iteration 10 discards the partial product.
        @(negedge clk);
        a = 32'd3; b = 32'd5; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("op mid_reset busy=%0d done=%0d hi=%h lo=%h", busy, done, hi, lo);
        check("mid_reset_state", {30'h0, busy, done, hi}, 64'h0);
        check("mid_reset_lo", {32'h0, lo}, 64'h0);
        seen_done = 1'b0;
        for (waitc = 0; waitc < 40; waitc++) begin
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        check("mid_reset_quiet", {63'h0, seen_done}, 64'h0);
        run_check("after_reset", 32'd2, 32'd2, 1'b0, -1, 64'd4);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i == 0) ra = 32'h0;
            if (i == 1) rb = 32'h80000000;
            run_check($sformatf("rand%0d", i), ra, rb, rs, -1, ref_prod(ra, rb, rs));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
